led_code_tx: RTL

- Serial "blink-code" transmitter that drives a single board LED. It is the output-side counterpart of the debounced switch input path.
- Accepts an NBITS-wide code word over a valid/ready handshake.
- Sends the word MSB first as timed LED on/off pulses: a long mark for 1, a short mark for 0, then an inter-word gap.
- Time base is a clk prescaler of 2^DIV_BITS cycles per tick, matching the board's ~1 kHz tick from the 33 MHz clock.

---
 rtl/led_code_tx.sv | 101 ++++++++++
 1 files changed

// File: rtl/led_code_tx.sv
// Blink-code LED transmitter: sends a code word MSB first as long (1) or short (0)
// LED marks, each bit padded to four units, followed by an LED-off inter-word gap.
module led_code_tx #(
    parameter int DIV_BITS   = 15,
    parameter int UNIT_TICKS = 100,
    parameter int NBITS      = 8,
    parameter int GAP_UNITS  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [NBITS-1:0] cmd_data,
    output logic             led_out,
    output logic             busy
);

    // Handshake: a word transfers on any posedge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, so inputs are ignored for the whole word.

    localparam int MAX_UNITS = (GAP_UNITS > 3) ? GAP_UNITS : 3;
    localparam int PH_MAX    = MAX_UNITS * UNIT_TICKS;
    localparam int CW        = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int BW        = (NBITS > 1) ? $clog2(NBITS) : 1;

    localparam logic [CW-1:0] LAST_1U  = CW'(UNIT_TICKS - 1);
    localparam logic [CW-1:0] LAST_3U  = CW'(3 * UNIT_TICKS - 1);
    localparam logic [CW-1:0] LAST_GAP = CW'(GAP_UNITS * UNIT_TICKS - 1);

    typedef enum logic [1:0] {IDLE, MARK, SPACE, GAP} state_t;

    // state is left as a plain named signal so checkers can bind to it directly
    state_t              state;
    state_t              state_next;
    logic [DIV_BITS-1:0] presc;
    logic [CW-1:0]       phase_cnt;
    logic [CW-1:0]       phase_last;
    logic [BW-1:0]       bit_idx;
    logic [NBITS-1:0]    shreg;
    logic                tick;
    logic                phase_end;
    logic                accept;
    logic                cur_bit;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_comb begin
        cur_bit    = shreg[NBITS-1];
        tick       = &presc;
        accept     = (state == IDLE) && cmd_valid;
        phase_last = LAST_1U;
        case (state)
            MARK:    phase_last = cur_bit ? LAST_3U : LAST_1U;
            SPACE:   phase_last = cur_bit ? LAST_1U : LAST_3U;
            GAP:     phase_last = LAST_GAP;
            default: phase_last = LAST_1U;
        endcase
        phase_end = (state != IDLE) && tick && (phase_cnt == phase_last);

        state_next = state;
        case (state)
            IDLE:  if (cmd_valid) state_next = MARK;
            MARK:  if (phase_end) state_next = SPACE;
            SPACE: if (phase_end) state_next = (bit_idx == '0) ? GAP : MARK;
            GAP:   if (phase_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            presc     <= '0;
            phase_cnt <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            led_out   <= 1'b0;
        end else begin
            state   <= state_next;
            // LED is a registered copy of the phase, so it can only move at phase edges
            led_out <= (state_next == MARK);
            if (accept) begin
                presc     <= '0;
                phase_cnt <= '0;
                shreg     <= cmd_data;
                bit_idx   <= BW'(NBITS - 1);
            end else if (state != IDLE) begin
                presc <= presc + 1'b1;
                if (tick) begin
                    phase_cnt <= phase_end ? '0 : phase_cnt + 1'b1;
                end
                if (state == SPACE && phase_end) begin
                    shreg   <= shreg << 1;
                    bit_idx <= bit_idx - 1'b1;
                end
            end
        end
    end

endmodule
